// File: rtl/cmdspi_pkg.sv
// Shared cmdspi definitions: field widths, R/W encoding, master FSM states and frame packing.
// Pure declarations; no timing, no flow control.
package cmdspi_pkg;
  localparam int CMDSPI_ADDR_W  = 7;
  localparam int CMDSPI_DATA_W  = 32;
  localparam int CMDSPI_FRAME_W = 40;

  localparam logic CMDSPI_RW_WRITE = 1'b0;
  localparam logic CMDSPI_RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } cmdspi_state_t;

  // Reads carry an all-zero data field on the wire.
  function automatic logic [CMDSPI_FRAME_W-1:0] cmdspi_frame(
    input logic                     rd,
    input logic [CMDSPI_ADDR_W-1:0] addr,
    input logic [CMDSPI_DATA_W-1:0] wdat
  );
    return {rd, addr, (rd == CMDSPI_RW_READ) ? {CMDSPI_DATA_W{1'b0}} : wdat};
  endfunction
endpackage

// File: rtl/cmdspi_master_tick.sv
// Loadable down-counter; tick is high while the count is zero (phase end), one cycle after
// the count runs out. Load has priority; the counter parks at zero until reloaded.
module cmdspi_master_tick #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tick = (cnt == '0);
endmodule

// File: rtl/cmdspi_master.sv
// SPI command master: one request at a time, 40b frame, 82*CLK_DIV+CSN_GAP cycles accept to ready;
// req_ready only in IDLE. CMDSPI_MASTER_MISO_SYNC_EN adds a 2-flop MISO synchroniser.
module cmdspi_master
  import cmdspi_pkg::*;
#(
  parameter int CLK_DIV = 8,
  parameter int CSN_GAP = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_rd,
  input  logic [CMDSPI_ADDR_W-1:0] req_addr,
  input  logic [CMDSPI_DATA_W-1:0] req_wdat,
  output logic                     rsp_valid,
  output logic [CMDSPI_DATA_W-1:0] rsp_rdat,
  output logic                     busy,
  output logic                     CSN,
  output logic                     SCLK,
  output logic                     MOSI,
  input  logic                     MISO
);
  localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LD = 8'(CSN_GAP - 1);

  cmdspi_state_t             state_q, state_d;
  logic                      tick, load;
  logic [7:0]                load_val;
  logic                      accept, sclk_rise, sclk_fall, frame_end;
  logic [5:0]                bit_q, nxt_bit;
  logic [CMDSPI_FRAME_W-1:0] tx_q;
  logic [CMDSPI_DATA_W-1:0]  rx_q;
  logic                      rd_q;
  logic                      out_en_q;
  logic                      miso_s;

`ifdef CMDSPI_MASTER_MISO_SYNC_EN
  logic [1:0] miso_sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) miso_sync <= 2'b00;
    else        miso_sync <= {miso_sync[0], MISO};
  end
  assign miso_s = miso_sync[1];
`else
  assign miso_s = MISO;
`endif

  cmdspi_master_tick #(.W(8)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .tick     (tick)
  );

  // out_en_q keeps req_ready low while reset is asserted.
  assign req_ready = out_en_q && (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_val  = DIV_LD;
    accept    = 1'b0;
    sclk_rise = 1'b0;
    sclk_fall = 1'b0;
    frame_end = 1'b0;
    nxt_bit   = (state_q == ST_SETUP) ? 6'd39 : bit_q - 6'd1;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept  = 1'b1;
          load    = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          load      = 1'b1;
          sclk_rise = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // SCLK itself tells which half of the pulse we are in.
        if (tick) begin
          load = 1'b1;
          if (SCLK)               sclk_fall = 1'b1;
          else if (bit_q == 6'd0) state_d   = ST_HOLD;
          else                    sclk_rise = 1'b1;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          load      = 1'b1;
          load_val  = GAP_LD;
          frame_end = 1'b1;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CSN       <= 1'b1;
      SCLK      <= 1'b0;
      MOSI      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdat  <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rd_q      <= 1'b0;
      bit_q     <= 6'd0;
      out_en_q  <= 1'b0;
    end else begin
      out_en_q  <= 1'b1;
      rsp_valid <= frame_end;
      if (accept) begin
        tx_q  <= cmdspi_frame(req_rd, req_addr, req_wdat);
        rd_q  <= req_rd;
        CSN   <= 1'b0;
        MOSI  <= req_rd;
        bit_q <= 6'd39;
      end
      // Data bits of a read return on pulses 9..40, MSB first.
      if (sclk_rise) begin
        SCLK  <= 1'b1;
        bit_q <= nxt_bit;
        MOSI  <= tx_q[nxt_bit];
        if (rd_q && (nxt_bit < 6'd32)) rx_q <= {rx_q[CMDSPI_DATA_W-2:0], miso_s};
      end
      if (sclk_fall) SCLK <= 1'b0;
      if (frame_end) begin
        CSN <= 1'b1;
        if (rd_q) rsp_rdat <= rx_q;
      end
    end
  end
endmodule
